spi_burst_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared spi_master byte engine. It accepts bytes from requesters over a valid/ready interface and issues one tx_start per byte. It holds the grant for a whole burst, which ends at the byte flagged last. Requester 0 is the I2C bridge FIFO drain; requester 1 is a local register/config port. Arbitration between new bursts is round-robin.

---
 rtl/spi_burst_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_burst_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_arbiter.sv
// Two-requester burst arbiter/sequencer for the shared spi_master byte engine.
// Optional mid-burst stall timeout is enabled by defining BURST_TIMEOUT_EN.
module spi_burst_arbiter #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_last,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_last,
  output logic              r1_ready,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [DATA_W-1:0] spi_tx_byte,
  output logic              spi_tx_start,
  input  logic              spi_tx_done,
  output logic [1:0]        burst_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        gnt_q;
  logic              last_cur_q;
  logic              rr_last_q;
  logic [DATA_W-1:0] byte_q;
  logic              start_q;

  logic              sel1;
  logic              acc0;
  logic              acc1;
  logic              acc;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;

  // In IDLE a tie goes to whoever did not own the previous burst.
  always_comb begin
    sel1 = r1_valid;
    if (r0_valid && r1_valid) sel1 = ~rr_last_q;
    acc0 = 1'b0;
    acc1 = 1'b0;
    case (state_q)
      IDLE: begin
        acc0 = r0_valid && !sel1;
        acc1 = r1_valid && sel1;
      end
      HOLD: begin
        acc0 = gnt_q[0] && r0_valid;
        acc1 = gnt_q[1] && r1_valid;
      end
      default: begin
        acc0 = 1'b0;
        acc1 = 1'b0;
      end
    endcase
  end

  assign acc      = acc0 | acc1;
  assign acc_data = acc1 ? r1_data : r0_data;
  assign acc_last = acc1 ? r1_last : r0_last;

`ifdef BURST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] stall_q;
  logic [1:0]       abort_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      last_cur_q <= 1'b0;
      rr_last_q  <= 1'b1;
      byte_q     <= '0;
      start_q    <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      stall_q    <= '0;
      abort_q    <= 2'b00;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      abort_q <= 2'b00;
`endif
      // Accepts only occur in IDLE or HOLD, so they share one path.
      if (acc) begin
        byte_q     <= acc_data;
        last_cur_q <= acc_last;
        gnt_q      <= {acc1, acc0};
        start_q    <= 1'b1;
        state_q    <= LOAD;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          LOAD: state_q <= WAIT;
          WAIT: begin
            if (spi_tx_done) begin
              if (last_cur_q) begin
                rr_last_q <= gnt_q[1];
                gnt_q     <= 2'b00;
                state_q   <= IDLE;
              end else begin
                state_q   <= HOLD;
`ifdef BURST_TIMEOUT_EN
                stall_q   <= '0;
`endif
              end
            end
          end
          HOLD: begin
`ifdef BURST_TIMEOUT_EN
            if (stall_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              abort_q   <= gnt_q;
              rr_last_q <= gnt_q[1];
              gnt_q     <= 2'b00;
              state_q   <= IDLE;
            end else begin
              stall_q   <= stall_q + 1'b1;
            end
`else
            state_q <= HOLD;
`endif
          end
          default: begin
            gnt_q   <= 2'b00;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign r0_ready     = acc0;
  assign r1_ready     = acc1;
  assign gnt          = gnt_q;
  assign busy         = (state_q != IDLE);
  assign spi_tx_byte  = byte_q;
  assign spi_tx_start = start_q;

`ifdef BURST_TIMEOUT_EN
  assign burst_abort = abort_q;
`else
  // Timeout parameter has no effect without the stall counter.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign burst_abort    = 2'b00;
`endif

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Scoreboard bench for spi_burst_arbiter: directed bursts, expected starts queued,
// monitor compares every spi_tx_start and burst_abort against the queue.
module tb_spi_burst_arbiter;

`ifdef BURST_TIMEOUT_EN
  localparam int TO    = 16;
  localparam int STALL = 6;
`else
  localparam int TO    = 255;
  localparam int STALL = 50;
`endif

  typedef struct {
    logic [1:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       l;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [7:0] r0_data = '0, r1_data = '0;
  logic       r0_last = 1'b0, r1_last = 1'b0;
  logic       r0_ready, r1_ready;
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] spi_tx_byte;
  logic       spi_tx_start;
  logic       spi_tx_done = 1'b0;
  logic [1:0] burst_abort;

  spi_burst_arbiter #(.DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_ready(r1_ready),
    .gnt(gnt), .busy(busy), .spi_tx_byte(spi_tx_byte), .spi_tx_start(spi_tx_start),
    .spi_tx_done(spi_tx_done), .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_edge = 0;
  int    start_cnt = 0;
  int    acc0_cnt = 0;
  int    acc1_cnt = 0;
  bit    auto_en = 1'b1;
  exp_t  exp_q[$];
  logic [1:0] exp_abort[$];
  item_t r0_src[$];
  item_t r1_src[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Requester drivers: hold valid with the head item until a handshake.
  initial begin : drv0
    forever begin
      @(negedge clk);
      if (r0_src.size() > 0) begin
        r0_valid = 1'b1; r0_data = r0_src[0].b; r0_last = r0_src[0].l;
        #1;
        if (r0_ready && rst_n) begin void'(r0_src.pop_front()); acc0_cnt++; end
      end else r0_valid = 1'b0;
    end
  end

  initial begin : drv1
    forever begin
      @(negedge clk);
      if (r1_src.size() > 0) begin
        r1_valid = 1'b1; r1_data = r1_src[0].b; r1_last = r1_src[0].l;
        #1;
        if (r1_ready && rst_n) begin void'(r1_src.pop_front()); acc1_cnt++; end
      end else r1_valid = 1'b0;
    end
  end

  // spi_master stand-in: done pulse three cycles after each start.
  initial begin : spi_model
    forever begin
      @(negedge clk);
      if (auto_en && spi_tx_start) begin
        repeat (3) @(negedge clk);
        spi_tx_done = 1'b1;
        done_edge = cyc + 1;
        @(negedge clk);
        spi_tx_done = 1'b0;
      end
    end
  end

  // Monitor: every start and abort must match the head of its queue.
  initial begin : monitor
    logic prev_start;
    exp_t e;
    logic [1:0] ea;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_tx_start) begin
        start_cnt++;
        chk("start_width", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_start", {24'd0, spi_tx_byte}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, spi_tx_byte}, {24'd0, e.b});
          chk("tx_gnt", {30'd0, gnt}, {30'd0, e.g});
        end
      end
      if (burst_abort != 2'b00) begin
        if (exp_abort.size() == 0) chk("unexpected_abort", {30'd0, burst_abort}, 32'd0);
        else begin
          ea = exp_abort.pop_front();
          chk("abort_value", {30'd0, burst_abort}, {30'd0, ea});
          chk("abort_delay", cyc - done_edge, TO);
          chk("abort_gnt", {30'd0, gnt}, 32'd0);
        end
      end
      prev_start = spi_tx_start;
    end
  end

  task automatic sync();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_src.delete();
    r1_src.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] b);
    exp_t e;
    e.g = g; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input int r, input logic [7:0] b, input logic l);
    item_t it;
    it.b = b; it.l = l;
    if (r == 0) r0_src.push_back(it); else r1_src.push_back(it);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || r0_src.size() != 0 || r1_src.size() != 0) && n < 2000) begin
      sync();
      n++;
    end
    chk({name, "_drain_timeout"}, {31'd0, (n >= 2000)}, 32'd0);
  endtask

  task automatic wait_acc(input string name, input int r, input int base);
    int n;
    n = 0;
    while (((r == 0) ? acc0_cnt : acc1_cnt) == base && n < 200) begin
      sync();
      n++;
    end
    chk({name, "_accept_timeout"}, {31'd0, (n >= 200)}, 32'd0);
  endtask

  initial begin : main
    int s0, a0, a1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, spi_tx_start}, 32'd0);
    chk("rst_byte", {24'd0, spi_tx_byte}, 32'd0);
    chk("rst_abort", {30'd0, burst_abort}, 32'd0);
    rst_n = 1'b1;
    sync();

    // 1: single-byte burst from r0
    push_exp(2'b01, 8'hA5);
    push_r(0, 8'hA5, 1'b1);
    wait_drain("t1");
    chk("t1_gnt_idle", {30'd0, gnt}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_byte_held", {24'd0, spi_tx_byte}, 32'hA5);
    chk("t1_r0_accepts", acc0_cnt, 1);

    // 2: contention from reset alternates r0, r1, r0, r1
    do_reset();
    push_exp(2'b01, 8'h01); push_exp(2'b10, 8'h81);
    push_exp(2'b01, 8'h02); push_exp(2'b10, 8'h82);
    push_r(0, 8'h01, 1'b1); push_r(0, 8'h02, 1'b1);
    push_r(1, 8'h81, 1'b1); push_r(1, 8'h82, 1'b1);
    wait_drain("t2");

    // 3: r1 three-byte burst while r0 waits
    push_exp(2'b10, 8'h10); push_exp(2'b10, 8'h11);
    push_exp(2'b10, 8'h12); push_exp(2'b01, 8'h20);
    a1 = acc1_cnt;
    push_r(1, 8'h10, 1'b0); push_r(1, 8'h11, 1'b0); push_r(1, 8'h12, 1'b1);
    wait_acc("t3", 1, a1);
    push_r(0, 8'h20, 1'b1);
    wait_drain("t3");

    // 4: owner stalls in HOLD; non-owner must not be served meanwhile
    push_exp(2'b01, 8'h30); push_exp(2'b01, 8'h31); push_exp(2'b10, 8'h40);
    push_r(0, 8'h30, 1'b0);
    s0 = start_cnt + 1;
    while (exp_q.size() > 2 && start_cnt < s0 + 5) sync();
    repeat (6) sync();
    push_r(1, 8'h40, 1'b1);
    a1 = acc1_cnt;
    repeat (STALL) sync();
    chk("t4_starts_in_stall", start_cnt, s0);
    chk("t4_gnt_hold", {30'd0, gnt}, 32'h1);
    chk("t4_busy_hold", {31'd0, busy}, 32'd1);
    chk("t4_r1_not_served", acc1_cnt, a1);
    push_r(0, 8'h31, 1'b1);
    wait_drain("t4");

    // 5: reset during WAIT, then a stray done
    auto_en = 1'b0;
    push_exp(2'b01, 8'h50);
    push_r(0, 8'h50, 1'b0); push_r(0, 8'h51, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin sync(); n++; end
      chk("t5_start_timeout", {31'd0, (n >= 100)}, 32'd0);
    end
    sync(); sync();
    rst_n = 1'b0;
    r0_src.delete();
    #1;
    chk("t5_rst_gnt", {30'd0, gnt}, 32'd0);
    chk("t5_rst_start", {31'd0, spi_tx_start}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    s0 = start_cnt; a0 = acc0_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
    spi_tx_done = 1'b1;
    sync();
    spi_tx_done = 1'b0;
    repeat (5) sync();
    chk("t5_after_busy", {31'd0, busy}, 32'd0);
    chk("t5_after_gnt", {30'd0, gnt}, 32'd0);
    chk("t5_after_starts", start_cnt, s0);
    chk("t5_after_accepts", acc0_cnt, a0);
    auto_en = 1'b1;

`ifdef BURST_TIMEOUT_EN
    // 6: stall past the timeout aborts r0, then r1 is granted
    do_reset();
    push_exp(2'b01, 8'h60); push_exp(2'b10, 8'h70);
    exp_abort.push_back(2'b01);
    a0 = acc0_cnt;
    push_r(0, 8'h60, 1'b0);
    wait_acc("t6", 0, a0);
    push_r(1, 8'h70, 1'b1);
    wait_drain("t6");
    chk("t6_abort_seen", exp_abort.size(), 0);
`endif

    repeat (3) sync();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_abort_empty", exp_abort.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
